// File: rtl/dstack_regs.sv
// Data-stack storage: top DEPTH words as a shift-register array driven by the stack control decode.
// Optional occupancy/overflow/underflow tracking is built when DSTACK_FAULT_EN is defined.
module dstack_regs #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  rotate,
  input  logic [5:0]            rotate_addr,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [6:0]            occupancy,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [1:0] {
    MV_REPLACE = 2'b00,
    MV_PUSH    = 2'b01,
    MV_POP1    = 2'b10,
    MV_POP2    = 2'b11
  } movement_e;

  logic [WORD_WIDTH-1:0] r_entry [DEPTH];
  logic [WORD_WIDTH-1:0] w_next  [DEPTH];
  movement_e             w_mv;
  logic                  w_addr_in_range;
  logic                  w_rot_en;

  assign w_mv            = movement_e'(movement);
  assign w_addr_in_range = ({1'b0, rotate_addr} < 7'(DEPTH));
  // An out-of-range rotate degenerates to a plain replace of the top.
  assign w_rot_en        = rotate && w_addr_in_range;

  assign w_next[0] = next_top;

  for (genvar g = 1; g < DEPTH; g++) begin : g_shift
    logic [WORD_WIDTH-1:0] w_above;
    logic [WORD_WIDTH-1:0] w_below1;
    logic [WORD_WIDTH-1:0] w_below2;
    logic [WORD_WIDTH-1:0] w_sel;

    assign w_above = r_entry[g-1];

    if (g + 1 < DEPTH) begin : g_b1
      assign w_below1 = r_entry[g+1];
    end else begin : g_b1_fill
      assign w_below1 = '0;
    end

    if (g + 2 < DEPTH) begin : g_b2
      assign w_below2 = r_entry[g+2];
    end else begin : g_b2_fill
      assign w_below2 = '0;
    end

    // NOTE: default assignment first so every path drives w_sel and no latch is inferred.
    always_comb begin
      w_sel = r_entry[g];
      unique case (w_mv)
        MV_REPLACE: if (w_rot_en && (rotate_addr >= 6'(g))) w_sel = w_above;
        MV_PUSH:    w_sel = w_above;
        MV_POP1:    w_sel = w_below1;
        MV_POP2:    w_sel = w_below2;
        default:    w_sel = r_entry[g];
      endcase
    end

    assign w_next[g] = w_sel;
  end

  // NOTE: the entries are architectural state that must read as zero after reset,
  // so the whole array is reset here rather than left as an uninitialised memory.
  // NOTE: non-blocking assignments keep every entry sampling the old array values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (!halt) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= w_next[i];
    end
  end

  assign top          = r_entry[0];
  assign second       = r_entry[1];
  assign third        = r_entry[2];
  assign rotate_value = w_addr_in_range ? r_entry[rotate_addr] : '0;

`ifdef DSTACK_FAULT_EN
  logic [6:0] r_occ;
  logic       r_overflow;
  logic       r_underflow;
  logic       w_read_past;

  // A push carrying rotate marks a copy; the data path ignores rotate there but the read is still checked.
  assign w_read_past = rotate && ({1'b0, rotate_addr} >= r_occ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!halt) begin
      unique case (w_mv)
        MV_REPLACE: begin
          if (w_read_past) r_underflow <= 1'b1;
        end
        MV_PUSH: begin
          if (r_occ == 7'(DEPTH)) r_overflow <= 1'b1;
          else                    r_occ      <= r_occ + 7'd1;
          if (w_read_past) r_underflow <= 1'b1;
        end
        MV_POP1: begin
          if (r_occ == 7'd0) r_underflow <= 1'b1;
          else               r_occ       <= r_occ - 7'd1;
        end
        MV_POP2: begin
          if (r_occ < 7'd2) begin
            r_underflow <= 1'b1;
            r_occ       <= '0;
          end else begin
            r_occ <= r_occ - 7'd2;
          end
        end
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign occupancy = '0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dstack_regs.sv
// Scoreboard bench for dstack_regs: the driver queues hand-computed expectations,
// a monitor process pops and compares them against the live outputs.
module tb_dstack_regs;
  localparam int W = 32;
  localparam int D = 64;
`ifdef DSTACK_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [1:0] REPL = 2'b00, PUSH = 2'b01, POP1 = 2'b10, POP2 = 2'b11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         halt;
  logic [1:0]   movement;
  logic [W-1:0] next_top;
  logic         rotate;
  logic [5:0]   rotate_addr;
  logic [W-1:0] top, second, third, rotate_value;
  logic [6:0]   occupancy;
  logic         overflow, underflow;

  dstack_regs #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .movement(movement),
    .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
    .top(top), .second(second), .third(third), .rotate_value(rotate_value),
    .occupancy(occupancy), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] top, second, third, rv;
    logic [6:0]   occ;
    logic         ovf, unf;
    logic [2:0]   kind; // 1 stack, 2 rotate_value, 4 flags
  } exp_t;

  exp_t exp_q[$];
  event exp_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string n, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(exp_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.kind[0]) begin
          check({e.name, ".top"}, top, e.top);
          check({e.name, ".second"}, second, e.second);
          check({e.name, ".third"}, third, e.third);
        end
        if (e.kind[1]) check({e.name, ".rotate_value"}, rotate_value, e.rv);
        if (e.kind[2]) begin
          check({e.name, ".occupancy"}, W'(occupancy), W'(e.occ));
          check({e.name, ".overflow"}, W'(overflow), W'(e.ovf));
          check({e.name, ".underflow"}, W'(underflow), W'(e.unf));
        end
      end
    end
  end

  function automatic exp_t blank(input string n, input logic [2:0] k);
    exp_t e;
    e.name = n; e.top = '0; e.second = '0; e.third = '0; e.rv = '0;
    e.occ = '0; e.ovf = 1'b0; e.unf = 1'b0; e.kind = k;
    return e;
  endfunction

  task automatic post(input exp_t e);
    exp_q.push_back(e);
    -> exp_ev;
    #1;
  endtask

  task automatic exp_stack(input string n, input logic [W-1:0] t, s, th);
    exp_t e = blank(n, 3'b001);
    e.top = t; e.second = s; e.third = th;
    post(e);
  endtask

  task automatic exp_rv(input string n, input logic [W-1:0] v);
    exp_t e = blank(n, 3'b010);
    e.rv = v;
    post(e);
  endtask

  task automatic exp_flags(input string n, input logic [6:0] occ, input logic ovf, input logic unf);
    exp_t e = blank(n, 3'b100);
    if (FAULT_EN) begin
      e.occ = occ; e.ovf = ovf; e.unf = unf;
    end
    post(e);
  endtask

  task automatic cmd(input logic [1:0] mv, input logic [W-1:0] nt, input logic rot,
                     input logic [5:0] addr, input logic h = 1'b0);
    movement = mv; next_top = nt; rotate = rot; rotate_addr = addr; halt = h;
    @(posedge clk);
    #1;
    halt = 1'b1;
    rotate = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    halt = 1'b1;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timed out");
  end

  initial begin : driver
    reset_n = 1'b0; halt = 1'b1; movement = REPL; next_top = '0; rotate = 1'b0; rotate_addr = '0;
    #12;
    exp_stack("por", 0, 0, 0);
    exp_rv("por", 0);
    exp_flags("por", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a cycle
    cmd(PUSH, 5, 0, 0);
    cmd(PUSH, 6, 0, 0);
    exp_stack("pre_rst", 6, 5, 0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_stack("async_rst", 0, 0, 0);
    exp_rv("async_rst", 0);
    exp_flags("async_rst", 0, 0, 0);
    reset_n = 1'b1;

    // Push, replace, halt
    cmd(PUSH, 1, 0, 0);
    cmd(PUSH, 2, 0, 0);
    cmd(PUSH, 3, 0, 0);
    exp_stack("push3", 3, 2, 1);
    exp_flags("push3", 3, 0, 0);
    cmd(REPL, 9, 0, 0);
    exp_stack("replace", 9, 2, 1);
    cmd(PUSH, 7, 0, 0, 1'b1);
    exp_stack("halt", 9, 2, 1);
    exp_flags("halt", 3, 0, 0);

    // Pops
    do_reset();
    for (int i = 1; i <= 5; i++) cmd(PUSH, W'(i), 0, 0);
    exp_stack("push5", 5, 4, 3);
    cmd(POP1, 3, 0, 0);
    exp_stack("pop1", 3, 3, 2);
    exp_flags("pop1", 4, 0, 0);
    cmd(POP2, 0, 0, 0);
    exp_stack("pop2", 0, 1, 0);
    exp_flags("pop2", 2, 0, 0);

    // Rotate
    do_reset();
    cmd(PUSH, 40, 0, 0);
    cmd(PUSH, 30, 0, 0);
    cmd(PUSH, 20, 0, 0);
    cmd(PUSH, 10, 0, 0);
    rotate_addr = 6'd3;
    #1;
    exp_rv("rot_read", 40);
    cmd(REPL, 40, 1, 3);
    exp_stack("rot3", 40, 10, 20);
    exp_rv("rot3_e3", 30);
    cmd(REPL, 40, 1, 0);
    exp_stack("rot0", 40, 10, 20);
    exp_flags("rot", 4, 0, 0);

    // Copy
    do_reset();
    cmd(PUSH, 30, 0, 0);
    cmd(PUSH, 20, 0, 0);
    cmd(PUSH, 10, 0, 0);
    rotate_addr = 6'd2;
    #1;
    exp_rv("copy_read", 30);
    cmd(PUSH, 30, 0, 2);
    exp_stack("copy", 30, 10, 20);
    rotate_addr = 6'd3;
    #1;
    exp_rv("copy_e3", 30);
    exp_flags("copy", 4, 0, 0);

    // Overflow: DEPTH+1 pushes
    do_reset();
    for (int i = 0; i <= D; i++) begin
      cmd(PUSH, W'(100 + i), 0, 0);
      if (i == D - 1) exp_flags("full", 7'(D), 0, 0);
    end
    exp_flags("overflow", 7'(D), 1, 0);
    exp_stack("overflow", W'(100 + D), W'(99 + D), W'(98 + D));
    rotate_addr = 6'(D - 1);
    #1;
    exp_rv("bottom", 101);

    // Underflow on pop two from empty
    do_reset();
    cmd(POP2, 0, 0, 0);
    exp_stack("pop2_empty", 0, 0, 0);
    exp_flags("pop2_empty", 0, 0, 1);

    // Underflow on rotate past occupancy
    do_reset();
    cmd(PUSH, 1, 0, 0);
    cmd(PUSH, 2, 0, 0);
    cmd(PUSH, 3, 0, 0);
    rotate_addr = 6'd5;
    #1;
    exp_rv("rot5_read", 0);
    cmd(REPL, 0, 1, 5);
    exp_stack("rot5", 0, 3, 2);
    exp_flags("rot5", 3, 0, 1);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
